// File: rtl/serial_word_tx_if.sv
// Handshake and serial-output bundle for serial_word_tx.
// master drives start/data; slave returns the bit stream.
interface serial_word_tx_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] data;
  logic             ready;
  logic             x;
  logic             x_valid;
  logic             exp_y;
  logic             done;

  modport master (
    output start, data,
    input  ready, x, x_valid, exp_y, done
  );

  modport slave (
    input  start, data,
    output ready, x, x_valid, exp_y, done
  );
endinterface

// File: rtl/serial_word_tx.sv
// MSB-first serial word transmitter with a running
// "prefix divisible by DIV" golden flag alongside each bit.
module serial_word_tx #(
  parameter int WIDTH = 8,
  parameter int DIV   = 2,
  parameter int GAP   = 1
) (
  input logic               clk,
  input logic               rst,
  serial_word_tx_if.slave   bus
);
  localparam int RW = $clog2(DIV);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [RW:0]   DIVW = (RW + 1)'(DIV);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);
  localparam logic [GW-1:0] GEND = GW'(GAP);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t           r_state, w_state;
  logic [WIDTH-1:0] r_shift, w_shift;
  logic [CW-1:0]    r_cnt, w_cnt;
  logic [GW-1:0]    r_gcnt, w_gcnt;
  logic [RW-1:0]    r_rem, w_rem;
  logic             r_ready, w_ready;
  logic             r_x, w_x;
  logic             r_xv, w_xv;
  logic             r_ey, w_ey;
  logic             r_done, w_done;

  // 2r+b < 2*DIV, so one conditional subtract is a full mod.
  function automatic logic [RW-1:0] step(
    input logic [RW-1:0] r,
    input logic          b
  );
    logic [RW:0] t;
    t = {r, b};
    if (t >= DIVW) t = t - DIVW;
    return t[RW-1:0];
  endfunction

  always_comb begin
    w_state = r_state;
    w_shift = r_shift;
    w_cnt   = r_cnt;
    w_gcnt  = r_gcnt;
    w_rem   = r_rem;
    w_ready = r_ready;
    w_x     = 1'b0;
    w_xv    = 1'b0;
    w_ey    = 1'b0;
    w_done  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (bus.start) begin
          w_rem   = step('0, bus.data[WIDTH-1]);
          w_x     = bus.data[WIDTH-1];
          w_xv    = 1'b1;
          w_ey    = (w_rem == '0);
          w_done  = (WIDTH == 1);
          w_cnt   = CW'(1);
          w_shift = bus.data << 1;
          w_ready = 1'b0;
          w_state = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_cnt == LAST) begin
          w_cnt = '0;
          if (GAP > 0) begin
            w_gcnt  = GW'(1);
            w_state = S_GAP;
          end else begin
            w_ready = 1'b1;
            w_state = S_IDLE;
          end
        end else begin
          w_rem   = step(r_rem, r_shift[WIDTH-1]);
          w_x     = r_shift[WIDTH-1];
          w_xv    = 1'b1;
          w_ey    = (w_rem == '0);
          w_done  = (r_cnt == LAST - CW'(1));
          w_cnt   = r_cnt + CW'(1);
          w_shift = r_shift << 1;
        end
      end
      S_GAP: begin
        if (r_gcnt == GEND) begin
          w_gcnt  = '0;
          w_ready = 1'b1;
          w_state = S_IDLE;
        end else begin
          w_gcnt = r_gcnt + GW'(1);
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_gcnt  <= '0;
      r_rem   <= '0;
      r_ready <= 1'b1;
      r_x     <= 1'b0;
      r_xv    <= 1'b0;
      r_ey    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_shift <= w_shift;
      r_cnt   <= w_cnt;
      r_gcnt  <= w_gcnt;
      r_rem   <= w_rem;
      r_ready <= w_ready;
      r_x     <= w_x;
      r_xv    <= w_xv;
      r_ey    <= w_ey;
      r_done  <= w_done;
    end
  end

  assign bus.ready   = r_ready;
  assign bus.x       = r_x;
  assign bus.x_valid = r_xv;
  assign bus.exp_y   = r_ey;
  assign bus.done    = r_done;
endmodule

// File: tb/tb_serial_word_tx.sv
// Bench for serial_word_tx: four configurations share one
// stimulus stream and are checked against a queue model.
module tb_serial_word_tx;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data = 8'h00;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  serial_word_tx_if #(.WIDTH(8)) ifa ();
  serial_word_tx_if #(.WIDTH(8)) ifb ();
  serial_word_tx_if #(.WIDTH(8)) ifc ();
  serial_word_tx_if #(.WIDTH(1)) ifd ();

  assign ifa.start = start;
  assign ifb.start = start;
  assign ifc.start = start;
  assign ifd.start = start;
  assign ifa.data  = data;
  assign ifb.data  = data;
  assign ifc.data  = data;
  assign ifd.data  = data[0:0];

  serial_word_tx #(.WIDTH(8), .DIV(2), .GAP(1)) u_a (
    .clk(clk), .rst(rst), .bus(ifa));
  serial_word_tx #(.WIDTH(8), .DIV(3), .GAP(1)) u_b (
    .clk(clk), .rst(rst), .bus(ifb));
  serial_word_tx #(.WIDTH(8), .DIV(5), .GAP(0)) u_c (
    .clk(clk), .rst(rst), .bus(ifc));
  serial_word_tx #(.WIDTH(1), .DIV(2), .GAP(2)) u_d (
    .clk(clk), .rst(rst), .bus(ifd));

  // {ready, x, x_valid, exp_y, done}
  logic [4:0] act [4];
  assign act[0] = {ifa.ready, ifa.x, ifa.x_valid,
                   ifa.exp_y, ifa.done};
  assign act[1] = {ifb.ready, ifb.x, ifb.x_valid,
                   ifb.exp_y, ifb.done};
  assign act[2] = {ifc.ready, ifc.x, ifc.x_valid,
                   ifc.exp_y, ifc.done};
  assign act[3] = {ifd.ready, ifd.x, ifd.x_valid,
                   ifd.exp_y, ifd.done};

  localparam logic [4:0] IDLE_O = 5'b10000;

  function automatic int pw(input int i);
    return (i == 3) ? 1 : 8;
  endfunction
  function automatic int pdiv(input int i);
    case (i)
      1: return 3;
      2: return 5;
      default: return 2;
    endcase
  endfunction
  function automatic int pgap(input int i);
    case (i)
      2: return 0;
      3: return 2;
      default: return 1;
    endcase
  endfunction

  logic [4:0] q [4][$];
  logic [4:0] cur [4];

  // Model: an accepted word expands into its whole future
  // output trace; an empty queue means idle and ready.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        q[i].delete();
        cur[i] = IDLE_O;
      end else if (cur[i][4] && start) begin
        int w, dv, pre, bt, wd;
        w   = pw(i);
        dv  = pdiv(i);
        wd  = (i == 3) ? int'(data[0]) : int'(data);
        pre = 0;
        for (int k = 1; k <= w; k++) begin
          bt  = (wd >> (w - k)) & 1;
          pre = pre * 2 + bt;
          q[i].push_back({1'b0, bt[0], 1'b1,
                          (pre % dv) == 0, k == w});
        end
        for (int g = 0; g < pgap(i); g++)
          q[i].push_back(5'b00000);
        cur[i] = q[i].pop_front();
      end else if (q[i].size() > 0) begin
        cur[i] = q[i].pop_front();
      end else begin
        cur[i] = IDLE_O;
      end
    end
    if (rst) chk_en = 1'b1;
  end

  task automatic chk(input string nm,
                     input logic [31:0] a,
                     input logic [31:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               nm, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 4; i++)
        chk($sformatf("model_dut%0d", i),
            32'(act[i]), 32'(cur[i]));
    end
  end

  logic [7:0] lit_x   = 8'hAC;
  logic [7:0] lit_ey2 = 8'b01010011;
  logic [7:0] lit_ey3 = 8'b00001000;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic check_word_a(input string tag);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      start = 1'b0;
      chk({tag, "_x"}, 32'(ifa.x), 32'(lit_x[8-k]));
      chk({tag, "_xv"}, 32'(ifa.x_valid), 32'd1);
      chk({tag, "_ey2"}, 32'(ifa.exp_y),
          32'(lit_ey2[8-k]));
      chk({tag, "_ey3"}, 32'(ifb.exp_y),
          32'(lit_ey3[8-k]));
      chk({tag, "_done"}, 32'(ifa.done), 32'(k == 8));
      chk({tag, "_mx"}, 32'(cur[0][3]), 32'(lit_x[8-k]));
      if (k == 3) begin
        start = 1'b1;
        data  = 8'hFF;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    chk("rst_ready", 32'(ifa.ready), 32'd1);
    chk("rst_out", 32'(act[1]), 32'(IDLE_O));
    cyc();

    // Scenarios 1-3: 0xAC, with a stray start mid-word.
    start = 1'b1;
    data  = 8'hAC;
    check_word_a("s1");
    cyc();
    start = 1'b0;
    chk("s1_gap_ready", 32'(ifa.ready), 32'd0);
    chk("s1_gap_xv", 32'(ifa.x_valid), 32'd0);
    cyc();
    chk("s1_ready_back", 32'(ifa.ready), 32'd1);
    chk("s3_no_second", 32'(ifb.x_valid), 32'd0);
    repeat (4) cyc();

    // Scenario 4: GAP=0, start held, 0x01 then 0x80.
    start = 1'b1;
    data  = 8'h01;
    for (int k = 1; k <= 17; k++) begin
      cyc();
      if (k == 1) data = 8'h80;
      chk("s4_xv", 32'(ifc.x_valid), 32'(k != 9));
      chk("s4_done", 32'(ifc.done),
          32'(k == 8 || k == 17));
      if (k == 9) chk("s4_ready", 32'(ifc.ready), 32'd1);
      if (k == 10) chk("s4_x80", 32'(ifc.x), 32'd1);
    end
    start = 1'b0;
    repeat (20) cyc();

    // Scenario 5: reset mid-word, then a fresh word.
    start = 1'b1;
    data  = 8'h5B;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      start = 1'b0;
      if (k == 4) rst = 1'b1;
    end
    cyc();
    rst = 1'b0;
    chk("s5_idle", 32'(act[0]), 32'(IDLE_O));
    chk("s5_idle_b", 32'(act[1]), 32'(IDLE_O));
    start = 1'b1;
    data  = 8'hAC;
    check_word_a("s5");
    start = 1'b0;
    repeat (4) cyc();

    // Scenario 6: reset and start together.
    rst   = 1'b1;
    start = 1'b1;
    data  = 8'hAC;
    cyc();
    chk("s6_idle", 32'(act[0]), 32'(IDLE_O));
    cyc();
    chk("s6_idle2", 32'(act[2]), 32'(IDLE_O));
    rst   = 1'b0;
    start = 1'b0;
    cyc();

    // Random traffic, checked by the model every cycle.
    for (int n = 0; n < 4000; n++) begin
      start = ($urandom_range(0, 2) == 0);
      data  = 8'($urandom);
      rst   = ($urandom_range(0, 199) == 0);
      cyc();
    end
    rst   = 1'b0;
    start = 1'b0;
    repeat (20) cyc();

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_word_tx.md
Name: serial_word_tx

Overview:
- Serial bit-stream transmitter that drives the single-bit `x` input of the team's serial divisibility detectors (`Divisible_by_N` family).
- Accepts a parallel word through a start/ready handshake and shifts it out MSB-first, one bit per clock.
- Alongside each bit it produces `exp_y`, the golden "prefix divisible by DIV" flag. A bench or self-check harness compares `exp_y` against the detector's `y`.

Parameters:
- WIDTH, 8, bits per word; minimum 1.
- DIV, 2, divisor for `exp_y`; minimum 2. The remainder register width is clog2(DIV).
- GAP, 1, idle cycles after each word before `ready` re-asserts; 0 is allowed.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request to send `data`; sampled only while `ready`=1.
- data  in  WIDTH  word to transmit; captured on the accepting edge.
- ready  out  1  high in IDLE only.
- x  out  1  serial bit, MSB first; 0 when `x_valid`=0.
- x_valid  out  1  high for exactly WIDTH consecutive cycles per word.
- exp_y  out  1  1 iff (value of all bits sent so far in this word) mod DIV == 0; 0 when `x_valid`=0.
- done  out  1  one-cycle pulse coincident with the last bit of a word.

Behaviour:
- All outputs are registered.
- Reset (rst=1 at an edge) gives: state=IDLE, ready=1, x=0, x_valid=0, exp_y=0, done=0, shift register=0, bit counter=0, remainder=0.
- Reset has priority over start in the same cycle.
- FSM has three states: IDLE, SHIFT, GAP.
  - IDLE: if start=1 at edge T, capture `data`, clear remainder, go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: emits one bit per cycle. After WIDTH bits, go to GAP if GAP>0, else go to IDLE.
  - GAP: count GAP cycles, then go to IDLE.
- Timing for a start accepted at edge T:
  - ready=0 from cycle T+1.
  - Cycle T+k for k=1..WIDTH: x = data[WIDTH-k], x_valid=1.
  - done=1 only in cycle T+WIDTH.
  - Cycles T+WIDTH+1 .. T+WIDTH+GAP: x_valid=0.
  - ready=1 again in cycle T+WIDTH+GAP+1.
  - Words are back-to-back when GAP=0: start held high gives continuous x_valid with one idle cycle, the ready cycle, between words.
- Remainder arithmetic:
  - r_next = (2*r + b) mod DIV, where b is the bit being emitted and r starts at 0 for each word.
  - exp_y = (r_next == 0), registered together with x so both appear in the same cycle.
  - Never compute the full prefix value. Use only the remainder, so any WIDTH is supported.
- start while ready=0 is ignored. It is not queued, and `data` changes are ignored.
- Reset mid-word: the word is aborted, no done pulse is produced, and the cycle after reset shows idle outputs with ready=1.
- WIDTH=1: a single x_valid cycle with done=1 in that same cycle.

Test Plan:
1. Reset, then WIDTH=8, DIV=2, data=8'hAC, start for 1 cycle -> x = 1,0,1,0,1,1,0,0 on T+1..T+8; exp_y = 0,1,0,1,0,0,1,1; done only at T+8; ready=1 at T+10.
2. DIV=3, data=8'hAC -> exp_y = 0,0,0,0,1,0,0,0 (prefix remainders 1,2,2,1,0,1,2,1); x sequence identical to scenario 1.
3. start pulsed at T+3 mid-word with data=8'hFF -> transmission of 8'hAC is unchanged; no second word; ready returns at T+10.
4. GAP=0, start held high, data=8'h01 then 8'h80 -> x_valid high T+1..T+8, low at T+9 (ready=1), high T+10..T+17; done pulses at T+8 and T+17.
5. rst=1 at T+4 during a word -> at T+5: x=0, x_valid=0, exp_y=0, done=0, ready=1; a new start at T+5 transmits a full fresh word with the remainder cleared.
6. rst=1 and start=1 in the same cycle -> no word is sent; outputs stay at reset values.
